// File: rtl/nco_mc_qw_pkg.sv
// nco_mc_pkg: shared constants, cfg_sel encoding and channel-width helper for the multi-channel NCO
package nco_mc_pkg;
  localparam int STAGES = 4;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  typedef enum logic {SEL_INC = 1'b0, SEL_OFF = 1'b1} cfg_sel_e;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nco_mc_qw_rom.sv
// nco_qw_rom: registered dual-read quarter-wave sine table
// Ports:
//   clk                clock
//   i_en               read enable; output registers hold when low
//   i_addr_a/i_addr_b  quarter-wave indices (RAW-2 bits)
//   o_a/o_b            registered table values T[addr], MPR bits
// Table: T[i] = round((2^(MPR-1)-1)*sin((i+0.5)*pi/2^(RAW-1))), built at elaboration.
module nco_qw_rom #(
  parameter int RAW = 12,
  parameter int MPR = 18
) (
  input  logic           clk,
  input  logic           i_en,
  input  logic [RAW-3:0] i_addr_a,
  input  logic [RAW-3:0] i_addr_b,
  output logic [MPR-1:0] o_a,
  output logic [MPR-1:0] o_b
);
  localparam int DEPTH = 2 ** (RAW - 2);
  localparam real PI = 3.14159265358979323846;
  logic [MPR-1:0] w_tbl [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_t
    localparam real A = (2.0 ** (MPR - 1) - 1.0) * $sin((i + 0.5) * PI / 2.0 ** (RAW - 1));
    assign w_tbl[i] = MPR'($rtoi(A + 0.5));
  end
  always_ff @(posedge clk)
    if (i_en) begin
      o_a <= w_tbl[i_addr_a];
      o_b <= w_tbl[i_addr_b];
    end
endmodule

// File: rtl/nco_mc_qw.sv
// nco_mc_qw: time-multiplexed multi-channel NCO with double-buffered config and quarter-wave sin/cos
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clken               clock enable for all datapath state
//   cfg_we/sel/ch/data  shadow register write (sel 0 = increment, 1 = phase offset)
//   cfg_commit          shadow -> active at next frame start
//   phase_clr           zero all accumulators at next frame start
//   fsin_o/fcos_o       sine/cosine samples, two's complement
//   out_ch, frame_o     sample channel, high on the channel-0 sample
//   out_valid           clken and pipeline filled
module nco_mc_qw
  import nco_mc_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int APR  = 32,
  parameter int APRP = 16,
  parameter int RAW  = 12,
  parameter int MPR  = 18
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           cfg_we,
  input  logic           cfg_sel,
  input  logic [2:0]     cfg_ch,
  input  logic [APR-1:0] cfg_data,
  input  logic           cfg_commit,
  input  logic           phase_clr,
  output logic [MPR-1:0] fsin_o,
  output logic [MPR-1:0] fcos_o,
  output logic [2:0]     out_ch,
  output logic           out_valid,
  output logic           frame_o
);
  localparam int CW = ch_w(NCH);
  logic [CW-1:0] r_ch, r_c0, r_c1, r_c2;
  logic [APR-1:0] r_acc [NCH];
  logic [APR-1:0] r_inc_a [NCH];
  logic [APR-1:0] r_inc_s [NCH];
  logic [APRP-1:0] r_off_a [NCH];
  logic [APRP-1:0] r_off_s [NCH];
  logic r_cpend, r_xpend;
  logic [2:0] r_fill;
  logic [RAW-1:0] r_p0, r_p1;
  logic [1:0] r_q2;
  logic w_fs, w_cmt, w_clr;
  logic [APR-1:0] w_a, w_i, w_ph;
  logic [APRP-1:0] w_o;
  logic [MPR-1:0] w_ta, w_tb, w_sin, w_cos;
  logic [CW-1:0] w_wch;
  assign w_fs = clken && r_ch == '0;
  assign w_cmt = w_fs && r_cpend;
  assign w_clr = w_fs && r_xpend;
  // on a committing frame start, slot 0 must already see the new values, so read shadow directly
  assign w_a = w_clr ? '0 : r_acc[r_ch];
  assign w_i = w_cmt ? r_inc_s[r_ch] : r_inc_a[r_ch];
  assign w_o = w_cmt ? r_off_s[r_ch] : r_off_a[r_ch];
  assign w_ph = w_a + {w_o, {(APR - APRP){1'b0}}};
  assign w_wch = cfg_ch[CW-1:0];
  assign out_valid = clken && r_fill == 3'(STAGES);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_inc_s <= '{default: '0};
      r_off_s <= '{default: '0};
    end else if (cfg_we && int'(cfg_ch) < NCH) begin
      if (cfg_sel_e'(cfg_sel) == SEL_OFF) r_off_s[w_wch] <= cfg_data[APRP-1:0];
      else r_inc_s[w_wch] <= cfg_data;
    end
  // a new request at the frame-start cycle survives the clear and applies next frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cpend <= 1'b0;
      r_xpend <= 1'b0;
    end else begin
      r_cpend <= cfg_commit || (r_cpend && !w_fs);
      r_xpend <= phase_clr || (r_xpend && !w_fs);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_ch <= '0;
      r_acc <= '{default: '0};
      r_inc_a <= '{default: '0};
      r_off_a <= '{default: '0};
      r_fill <= '0;
      r_p0 <= '0;
      r_p1 <= '0;
      r_q2 <= '0;
      r_c0 <= '0;
      r_c1 <= '0;
      r_c2 <= '0;
      fsin_o <= '0;
      fcos_o <= '0;
      out_ch <= '0;
      frame_o <= 1'b0;
    end else if (clken) begin
      r_ch <= r_ch == CW'(NCH - 1) ? '0 : r_ch + 1'b1;
      for (int k = 0; k < NCH; k++) if (w_clr) r_acc[k] <= '0;
      r_acc[r_ch] <= w_a + w_i;
      if (w_cmt) begin
        r_inc_a <= r_inc_s;
        r_off_a <= r_off_s;
      end
      r_fill <= r_fill == 3'(STAGES) ? r_fill : r_fill + 1'b1;
      r_p0 <= w_ph[APR-1 -: RAW];
      r_c0 <= r_ch;
      r_p1 <= r_p0;
      r_c1 <= r_c0;
      r_q2 <= r_p1[RAW-1 -: 2];
      r_c2 <= r_c1;
      fsin_o <= w_sin;
      fcos_o <= w_cos;
      out_ch <= 3'(r_c2);
      frame_o <= r_c2 == '0;
    end
  nco_qw_rom #(.RAW(RAW), .MPR(MPR)) u_rom (
    .clk(clk),
    .i_en(clken),
    .i_addr_a(r_p1[RAW-3:0]),
    .i_addr_b(~r_p1[RAW-3:0]),
    .o_a(w_ta),
    .o_b(w_tb)
  );
  // quadrant symmetry: T[~idx] supplies the mirrored half of each quadrant
  always_comb begin
    w_sin = w_ta;
    w_cos = w_tb;
    case (r_q2)
      Q0: begin w_sin = w_ta; w_cos = w_tb; end
      Q1: begin w_sin = w_tb; w_cos = -w_ta; end
      Q2: begin w_sin = -w_ta; w_cos = -w_tb; end
      Q3: begin w_sin = -w_tb; w_cos = w_ta; end
    endcase
  end
endmodule
